// File: rtl/uart_rx_intr.sv
// uart_rx_intr: 8N1 asynchronous serial receiver with a level interrupt.
//
// Each byte received on rxd is presented on r_data. irr is raised on the same
// edge and held until the CPU produces a rising edge on ack. Two sticky debug
// flags are provided: overrun (a byte landed on an unacknowledged one) and
// frame_err (stop bit sampled low).
//
// Ports:
//   clk        system clock
//   reset      asynchronous, active-high reset
//   rxd        serial line, idle high, asynchronous to clk
//   irr        byte-available interrupt request (level)
//   ack        CPU acknowledge; only its rising edge acts
//   r_data     last received byte, stable while irr=1
//   overrun    sticky overrun flag
//   frame_err  sticky framing error flag
module uart_rx_intr #(
  parameter int CLKS_PER_BIT = 234
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic       irr,
  input  logic       ack,
  output logic [7:0] r_data,
  output logic       overrun,
  output logic       frame_err
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int H  = CLKS_PER_BIT / 2;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(H - 1);

  typedef enum logic [2:0] {
    WAIT_HIGH,
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [2:0]      idx, idx_nxt;
  logic [7:0]      sh, sh_nxt;
  logic            rxd_p0, rxs;
  logic            ack_d;
  logic            ack_rise;
  logic            stop_ok, stop_bad;

  // Stage p0/p1: two-flop synchroniser; resets to the idle (high) level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rxd_p0 <= 1'b1;
      rxs    <= 1'b1;
    end else begin
      rxd_p0 <= rxd;
      rxs    <= rxd_p0;
    end
  end

  assign ack_rise = ack & ~ack_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= WAIT_HIGH;
      cnt   <= '0;
      idx   <= '0;
      sh    <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
      sh    <= sh_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    sh_nxt    = sh;
    stop_ok   = 1'b0;
    stop_bad  = 1'b0;
    case (state)
      // Refuse to arm until the line is seen idle, so a reset or a framing
      // error in the middle of a frame cannot lock onto a data bit.
      WAIT_HIGH: begin
        if (rxs) state_nxt = IDLE;
      end
      IDLE: begin
        if (!rxs) begin
          state_nxt = START;
          cnt_nxt   = '0;
        end
      end
      // Re-check the start bit at its centre; a high level here is a glitch.
      START: begin
        if (cnt == CNT_HALF) begin
          cnt_nxt   = '0;
          idx_nxt   = '0;
          state_nxt = rxs ? IDLE : DATA;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_nxt     = '0;
          sh_nxt[idx] = rxs;
          idx_nxt     = idx + 3'd1;
          if (idx == 3'd7) state_nxt = STOP;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      // Leaving for IDLE mid stop bit lets a back-to-back start bit be caught.
      STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_nxt = '0;
          if (rxs) begin
            stop_ok   = 1'b1;
            state_nxt = IDLE;
          end else begin
            stop_bad  = 1'b1;
            state_nxt = WAIT_HIGH;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = WAIT_HIGH;
    endcase
  end

  // Output stage: a new byte or a new flag always beats a coincident ack edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack_d     <= 1'b0;
      irr       <= 1'b0;
      r_data    <= '0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      ack_d <= ack;

      if (stop_ok) begin
        r_data <= sh;
        irr    <= 1'b1;
      end else if (ack_rise) begin
        irr <= 1'b0;
      end

      if (stop_ok && irr && !ack_rise) begin
        overrun <= 1'b1;
      end else if (ack_rise) begin
        overrun <= 1'b0;
      end

      if (stop_bad) begin
        frame_err <= 1'b1;
      end else if (ack_rise) begin
        frame_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_intr.sv
// Directed bench for uart_rx_intr with CLKS_PER_BIT=16 (H=8).
// Edge 0 of a frame is the first clk edge that samples the start bit at the
// pin; irr then rises on edge 2+H+9N = 154, i.e. the 155th edge counting
// edge 0 itself.
module tb_uart_rx_intr;

  localparam int N = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       rxd;
  logic       ack;
  logic       irr;
  logic [7:0] r_data;
  logic       overrun;
  logic       frame_err;

  int         n_checks = 0;
  int         n_errors = 0;
  int         rise_at;
  logic [9:0] fbits;

  uart_rx_intr #(.CLKS_PER_BIT(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .rxd       (rxd),
    .irr       (irr),
    .ack       (ack),
    .r_data    (r_data),
    .overrun   (overrun),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one 10-bit frame, one bit per N cycles, inputs changed on negedges.
  // ack is high for frame edges [ack_at, ack_at+ack_len). rise_at records the
  // frame edge index on which irr went 0->1 (-1 if it did not).
  task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                            input int ack_at, input int ack_len);
    logic [9:0] bits;
    logic       irr_prev;
    bits     = {stop_bit, b, 1'b0};
    rise_at  = -1;
    irr_prev = 1'b0;
    for (int j = 0; j < 10 * N; j++) begin
      @(negedge clk);
      if (j > 0 && irr && !irr_prev && rise_at < 0) rise_at = j - 1;
      irr_prev = irr;
      rxd = bits[j / N];
      ack = (j >= ack_at) && (j < ack_at + ack_len);
    end
  endtask

  initial begin
    reset = 1'b1;
    rxd   = 1'b1;
    ack   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_irr", irr, 0);
    check("rst_rdata", r_data, 0);
    check("rst_overrun", overrun, 0);
    check("rst_frame_err", frame_err, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // 1: single frame 0xA5, latency
    send_frame(8'hA5, 1'b1, -1, 0);
    check("s1_latency", rise_at + 1, 155);
    @(posedge clk);
    #1;
    check("s1_rdata", r_data, 8'hA5);
    check("s1_irr", irr, 1);
    check("s1_overrun", overrun, 0);
    check("s1_frame_err", frame_err, 0);

    // 2: 5-cycle ack pulse
    @(negedge clk);
    ack = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("s2_irr_clear", irr, 0);
    check("s2_rdata", r_data, 8'hA5);
    repeat (3) @(posedge clk);
    #1;
    check("s2_irr_held_ack", irr, 0);
    check("s2_rdata_held_ack", r_data, 8'hA5);
    @(negedge clk);
    ack = 1'b0;
    repeat (4) @(negedge clk);

    // 3: back-to-back 0x3C, 0xC3 without ack -> overrun
    send_frame(8'h3C, 1'b1, -1, 0);
    send_frame(8'hC3, 1'b1, -1, 0);
    @(posedge clk);
    #1;
    check("s3_rdata", r_data, 8'hC3);
    check("s3_irr", irr, 1);
    check("s3_overrun", overrun, 1);
    @(negedge clk);
    ack = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("s3_irr_ack", irr, 0);
    check("s3_overrun_ack", overrun, 0);
    @(negedge clk);
    ack = 1'b0;
    // byte completing under a long-held ack keeps irr
    send_frame(8'h5A, 1'b1, 0, 10 * N);
    @(posedge clk);
    #1;
    check("s3_long_ack_irr", irr, 1);
    check("s3_long_ack_rdata", r_data, 8'h5A);
    @(negedge clk);
    ack = 1'b0;
    @(negedge clk);
    ack = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("s3_long_ack_cleared", irr, 0);
    @(negedge clk);
    ack = 1'b0;
    repeat (4) @(negedge clk);

    // 4: bad stop bit, line held low, then 0x0F
    send_frame(8'h55, 1'b0, -1, 0);
    repeat (40) @(negedge clk);
    check("s4_frame_err", frame_err, 1);
    check("s4_irr", irr, 0);
    check("s4_rdata_kept", r_data, 8'h5A);
    rxd = 1'b1;
    repeat (200) @(negedge clk);
    check("s4_no_false_frame", irr, 0);
    send_frame(8'h0F, 1'b1, -1, 0);
    @(posedge clk);
    #1;
    check("s4_rdata", r_data, 8'h0F);
    check("s4_irr_next", irr, 1);
    check("s4_frame_err_sticky", frame_err, 1);

    // 5: clear, glitch, then ack coincident with a stop sample
    @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    @(posedge clk);
    #1;
    check("s5_frame_err_ack", frame_err, 0);
    check("s5_irr_ack", irr, 0);
    @(negedge clk);
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    rxd = 1'b1;
    repeat (200) @(negedge clk);
    check("s5_glitch_irr", irr, 0);
    check("s5_glitch_overrun", overrun, 0);
    check("s5_glitch_frame_err", frame_err, 0);
    send_frame(8'h7E, 1'b1, -1, 0);
    send_frame(8'h81, 1'b1, 154, 3);
    @(posedge clk);
    #1;
    check("s5_coinc_irr", irr, 1);
    check("s5_coinc_rdata", r_data, 8'h81);
    check("s5_coinc_overrun", overrun, 0);

    // 6: async reset during data bit 4 of 0xFF with the line low
    fbits = {1'b1, 8'hFF, 1'b0};
    for (int j = 0; j < 10 * N; j++) begin
      @(negedge clk);
      rxd = (j >= 5 * N && j < 6 * N) ? 1'b0 : fbits[j / N];
      if (j == 5 * N + 2) begin
        reset = 1'b1;
        #1;
        check("s6_rst_irr", irr, 0);
        check("s6_rst_rdata", r_data, 0);
        check("s6_rst_overrun", overrun, 0);
        check("s6_rst_frame_err", frame_err, 0);
      end
      if (j == 6 * N) reset = 1'b0;
    end
    repeat (200) @(negedge clk);
    check("s6_truncated_irr", irr, 0);
    check("s6_truncated_rdata", r_data, 0);
    send_frame(8'h12, 1'b1, -1, 0);
    @(posedge clk);
    #1;
    check("s6_rdata", r_data, 8'h12);
    check("s6_irr", irr, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
